// File: rtl/cim_job_sequencer.sv
// Job sequencer for the Basic_GeMM_CIM macro: loads weight rows from data RAM,
// clears the selected output register, streams input vectors with partial-sum
// accumulation and reports the macro result word.
module cim_job_sequencer #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             start,
  input  logic             abort,
  input  logic [AW-1:0]    cfg_wbase,
  input  logic [AW-1:0]    cfg_ibase,
  input  logic [CNT_W-1:0] cfg_rows,
  input  logic [CNT_W-1:0] cfg_nin,
  input  logic [1:0]       cfg_out,
  output logic             busy,
  output logic             done,
  output logic             res_valid,
  output logic [DW-1:0]    res_data,
  output logic             mem_rd,
  output logic [AW-1:0]    mem_addr,
  input  logic [DW-1:0]    mem_rdata,
  output logic             cim_we,
  output logic             cim_cime,
  output logic             cim_partial_sum_e,
  output logic             cim_reset_output_reg,
  output logic [3:0]       cim_output_reg,
  output logic [AW-1:0]    cim_address,
  output logic [DW-1:0]    cim_input_data,
  input  logic [DW-1:0]    cim_output
);

  typedef enum logic [3:0] {
    S_IDLE, S_WREQ, S_WWR, S_CLR, S_IREQ, S_CMP, S_WAIT, S_RES, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]      wbase_q, ibase_q;
  logic [CNT_W-1:0]   rows_q, nin_q;
  logic [1:0]         out_q;
  logic [DW-1:0]      res_data_q;
  logic               cfg_latch;
  logic               res_cap;
  logic [3:0]         sel_oh;

  assign sel_oh   = 4'(4'b0001 << out_q);
  assign res_data = res_data_q;

  // State register
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Row/vector counter, job configuration snapshot and result capture
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      cnt_q      <= '0;
      wbase_q    <= '0;
      ibase_q    <= '0;
      rows_q     <= '0;
      nin_q      <= '0;
      out_q      <= '0;
      res_data_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (cfg_latch) begin
        wbase_q <= cfg_wbase;
        ibase_q <= cfg_ibase;
        rows_q  <= cfg_rows;
        nin_q   <= cfg_nin;
        out_q   <= cfg_out;
      end
      if (res_cap) res_data_q <= cim_output;
    end
  end

  // Next-state and per-state strobe decode; abort overrides every transition
  always_comb begin
    state_d              = state_q;
    cnt_d                = cnt_q;
    cfg_latch            = 1'b0;
    res_cap              = 1'b0;
    busy                 = (state_q != S_IDLE);
    done                 = 1'b0;
    res_valid            = 1'b0;
    mem_rd               = 1'b0;
    mem_addr             = '0;
    cim_we               = 1'b0;
    cim_cime             = 1'b0;
    cim_partial_sum_e    = 1'b0;
    cim_reset_output_reg = 1'b0;
    cim_output_reg       = 4'b0000;
    cim_address          = '0;
    cim_input_data       = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_latch = 1'b1;
          cnt_d     = '0;
          state_d   = (cfg_rows != '0) ? S_WREQ : S_CLR;
        end
      end
      S_WREQ: begin
        mem_rd   = 1'b1;
        mem_addr = wbase_q + AW'(cnt_q);
        state_d  = S_WWR;
      end
      S_WWR: begin
        cim_we         = 1'b1;
        cim_address    = AW'(cnt_q);
        cim_input_data = mem_rdata;
        if (cnt_q == CNT_W'(rows_q - CNT_W'(1))) begin
          cnt_d   = '0;
          state_d = S_CLR;
        end else begin
          cnt_d   = CNT_W'(cnt_q + CNT_W'(1));
          state_d = S_WREQ;
        end
      end
      S_CLR: begin
        cim_reset_output_reg = 1'b1;
        cim_output_reg       = sel_oh;
        state_d              = (nin_q != '0) ? S_IREQ : S_DONE;
      end
      S_IREQ: begin
        mem_rd   = 1'b1;
        mem_addr = ibase_q + AW'(cnt_q);
        state_d  = S_CMP;
      end
      S_CMP: begin
        cim_cime          = 1'b1;
        cim_input_data    = mem_rdata;
        cim_output_reg    = sel_oh;
        cim_partial_sum_e = (cnt_q != '0);
        if (cnt_q == CNT_W'(nin_q - CNT_W'(1))) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d   = CNT_W'(cnt_q + CNT_W'(1));
          state_d = S_IREQ;
        end
      end
      S_WAIT: begin
        // macro output register is settled here; capture so res_data is valid with res_valid
        res_cap = 1'b1;
        state_d = S_RES;
      end
      S_RES: begin
        res_valid = 1'b1;
        done      = 1'b1;
        state_d   = S_IDLE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      res_cap   = 1'b0;
      done      = 1'b0;
      res_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_cim_job_sequencer.sv
// Scoreboard bench for cim_job_sequencer with behavioural RAM and CIM macro models.
module tb_cim_job_sequencer;

  logic        CLK = 1'b0;
  logic        RES = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_wbase = '0;
  logic [31:0] cfg_ibase = '0;
  logic [7:0]  cfg_rows = '0;
  logic [7:0]  cfg_nin = '0;
  logic [1:0]  cfg_out = '0;
  logic        busy, done, res_valid, mem_rd;
  logic [31:0] res_data, mem_addr, cim_address, cim_input_data, cim_output;
  logic [31:0] mem_rdata = '0;
  logic        cim_we, cim_cime, cim_partial_sum_e, cim_reset_output_reg;
  logic [3:0]  cim_output_reg;

  cim_job_sequencer #(.AW(32), .DW(32), .CNT_W(8)) dut (
    .CLK(CLK), .RES(RES), .start(start), .abort(abort),
    .cfg_wbase(cfg_wbase), .cfg_ibase(cfg_ibase), .cfg_rows(cfg_rows),
    .cfg_nin(cfg_nin), .cfg_out(cfg_out),
    .busy(busy), .done(done), .res_valid(res_valid), .res_data(res_data),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .cim_we(cim_we), .cim_cime(cim_cime), .cim_partial_sum_e(cim_partial_sum_e),
    .cim_reset_output_reg(cim_reset_output_reg), .cim_output_reg(cim_output_reg),
    .cim_address(cim_address), .cim_input_data(cim_input_data), .cim_output(cim_output)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ram_val(input logic [31:0] a);
    return 32'(a * 32'h0000_9E37 + 32'h0000_0055);
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  // RAM: registered read, data valid the cycle after mem_rd
  always @(posedge CLK) if (mem_rd) mem_rdata <= ram_val(mem_addr);

  // CIM macro: each compute adds (input + weight row 0) into the selected register
  logic [31:0] w0_m = '0;
  logic [31:0] oregs [4];
  logic [1:0]  last_sel = '0;
  initial for (int i = 0; i < 4; i++) oregs[i] = '0;
  assign cim_output = oregs[last_sel];

  always @(posedge CLK) begin
    if (cim_we && cim_address == 32'd0) w0_m <= cim_input_data;
    for (int i = 0; i < 4; i++) begin
      if (cim_output_reg[i]) begin
        last_sel <= 2'(i);
        if (cim_reset_output_reg) oregs[i] <= '0;
        else if (cim_cime)
          oregs[i] <= 32'((cim_partial_sum_e ? oregs[i] : 32'd0) + cim_input_data + w0_m);
      end
    end
  end

  typedef struct packed {
    logic [31:0] cyc;
    logic        rv;
    logic [31:0] rd;
  } done_t;

  logic [31:0] q_addr [$];
  logic [63:0] q_wr   [$];
  logic [3:0]  q_clr  [$];
  logic [36:0] q_cmp  [$];
  done_t       q_done [$];

  logic [31:0] exp_w0 = '0;
  logic [31:0] last_res = '0;
  logic [31:0] saved_res = '0;

  // Monitor: compare every DUT strobe against the scoreboard
  always @(negedge CLK) begin
    if (RES) begin
      if (mem_rd) begin
        if (q_addr.size() == 0) check("mem_rd_extra", 64'(1), 64'(0));
        else check("mem_addr", 64'(mem_addr), 64'(q_addr.pop_front()));
      end
      if (cim_we) begin
        if (q_wr.size() == 0) check("cim_we_extra", 64'(1), 64'(0));
        else check("cim_write", {cim_address, cim_input_data}, q_wr.pop_front());
      end
      if (cim_reset_output_reg) begin
        if (q_clr.size() == 0) check("clr_extra", 64'(1), 64'(0));
        else check("clr_sel", 64'(cim_output_reg), 64'(q_clr.pop_front()));
      end
      if (cim_cime) begin
        if (q_cmp.size() == 0) check("cime_extra", 64'(1), 64'(0));
        else check("cmp_psum_sel_data",
                   64'({cim_partial_sum_e, cim_output_reg, cim_input_data}),
                   64'(q_cmp.pop_front()));
      end
      if (res_valid && !done) check("res_valid_without_done", 64'(1), 64'(0));
      if (done) begin
        done_cnt++;
        if (q_done.size() == 0) check("done_extra", 64'(1), 64'(0));
        else begin
          done_t d;
          d = q_done.pop_front();
          check("done_cycle", 64'(cyc), 64'(d.cyc));
          check("res_valid", 64'(res_valid), 64'(d.rv));
          check("res_data", 64'(res_data), 64'(d.rd));
          check("busy_at_done", 64'(busy), 64'(1));
        end
      end
    end
  end

  task automatic flush_sb();
    q_addr.delete(); q_wr.delete(); q_clr.delete(); q_cmp.delete(); q_done.delete();
  endtask

  // Drive one start pulse and push the full expected transaction trace
  task automatic start_job(input logic [31:0] wb, input logic [31:0] ib,
                           input logic [7:0] r, input logic [7:0] n, input logic [1:0] o);
    logic [31:0] acc;
    int lat;
    done_t d;
    @(negedge CLK);
    cfg_wbase = wb; cfg_ibase = ib; cfg_rows = r; cfg_nin = n; cfg_out = o;
    start = 1'b1;
    if (r != 0) exp_w0 = ram_val(wb);
    for (int k = 0; k < int'(r); k++) begin
      q_addr.push_back(32'(wb + 32'(k)));
      q_wr.push_back({32'(k), ram_val(32'(wb + 32'(k)))});
    end
    q_clr.push_back(4'(4'b0001 << o));
    acc = '0;
    for (int j = 0; j < int'(n); j++) begin
      q_addr.push_back(32'(ib + 32'(j)));
      q_cmp.push_back({(j != 0), 4'(4'b0001 << o), ram_val(32'(ib + 32'(j)))});
      acc = 32'(acc + ram_val(32'(ib + 32'(j))) + exp_w0);
    end
    lat = (n != 0) ? (2 * int'(r) + 2 * int'(n) + 3) : (2 * int'(r) + 2);
    d.cyc = 32'(cyc + lat);
    d.rv  = (n != 0);
    d.rd  = (n != 0) ? acc : last_res;
    saved_res = last_res;
    last_res  = d.rd;
    q_done.push_back(d);
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 1000) begin
      @(posedge CLK);
      t++;
    end
    check("done_seen", 64'(done_cnt - d0), 64'(1));
    @(negedge CLK);
    check("idle_after_done", 64'(busy), 64'(0));
    check("sb_drained", 64'(q_addr.size() + q_wr.size() + q_clr.size() + q_cmp.size() + q_done.size()), 64'(0));
  endtask

  task automatic wait_strobe_n(input int which, input int n);
    int seen;
    seen = 0;
    for (int t = 0; t < 200 && seen < n; t++) begin
      @(negedge CLK);
      #1;
      if ((which == 0 && cim_we) || (which == 1 && cim_cime)) seen++;
    end
    check("strobe_reached", 64'(seen), 64'(n));
  endtask

  initial begin
    int d0;
    #1;
    check("reset_strobes", 64'({busy, done, res_valid, mem_rd, cim_we, cim_cime,
                                cim_partial_sum_e, cim_reset_output_reg, cim_output_reg}), 64'(0));
    check("reset_res_data", 64'(res_data), 64'(0));
    check("reset_addrs", {mem_addr, cim_address}, 64'(0));
    @(negedge CLK);
    RES = 1'b1;
    repeat (2) @(negedge CLK);

    // 1: two rows, three vectors, register 1
    d0 = done_cnt;
    start_job(32'h10, 32'h20, 8'd2, 8'd3, 2'd1);
    wait_done(d0);

    // 2: no weight load, single vector
    d0 = done_cnt;
    start_job(32'h40, 32'h55, 8'd0, 8'd1, 2'd0);
    wait_done(d0);

    // 3: one row, no compute; res_data keeps the previous result
    d0 = done_cnt;
    start_job(32'h70, 32'h80, 8'd1, 8'd0, 2'd2);
    wait_done(d0);

    // 4: weight address wraps past 2**32
    d0 = done_cnt;
    start_job(32'hFFFF_FFFF, 32'hFFFF_FFFE, 8'd2, 8'd3, 2'd3);
    wait_done(d0);

    // 5: abort during the second compute cycle, then a normal job
    d0 = done_cnt;
    start_job(32'h100, 32'h200, 8'd1, 8'd3, 2'd2);
    wait_strobe_n(1, 2);
    abort = 1'b1;
    @(negedge CLK);
    #1;
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_strobes", 64'({mem_rd, cim_we, cim_cime, cim_reset_output_reg, cim_output_reg}), 64'(0));
    flush_sb();
    last_res = saved_res;
    repeat (20) @(negedge CLK);
    check("abort_no_done", 64'(done_cnt), 64'(d0));
    check("abort_res_data_held", 64'(res_data), 64'(last_res));
    d0 = done_cnt;
    start_job(32'h300, 32'h400, 8'd1, 8'd1, 2'd0);
    wait_done(d0);

    // 6: asynchronous reset during the second weight write
    start_job(32'h500, 32'h600, 8'd2, 8'd1, 2'd1);
    wait_strobe_n(0, 2);
    RES = 1'b0;
    #1;
    check("midjob_reset_strobes", 64'({busy, done, res_valid, mem_rd, cim_we, cim_cime,
                                       cim_partial_sum_e, cim_reset_output_reg, cim_output_reg}), 64'(0));
    check("midjob_reset_addrs", {mem_addr, cim_address}, 64'(0));
    check("midjob_reset_data", {res_data, cim_input_data}, 64'(0));
    flush_sb();
    last_res = '0;
    @(negedge CLK);
    RES = 1'b1;
    repeat (2) @(negedge CLK);

    // start pulse and cfg changes while busy are ignored
    d0 = done_cnt;
    start_job(32'h700, 32'h800, 8'd2, 8'd2, 2'd3);
    @(negedge CLK);
    start = 1'b1; cfg_wbase = 32'h999; cfg_ibase = 32'hAAA; cfg_rows = 8'd5; cfg_nin = 8'd4; cfg_out = 2'd0;
    @(negedge CLK);
    start = 1'b0;
    wait_done(d0);
    repeat (5) @(negedge CLK);
    check("no_spurious_job", 64'(busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
